// File: rtl/dbg_run_ctrl.sv
// Run-control sequencer for the debug core: owns the dbg_clk gate enable,
// the enabled-cycle counter, multi-cycle stepping and the cycle breakpoint.
module dbg_run_ctrl #(
    parameter int CNT_W = 8,
    parameter int CYC_W = 16
) (
    input  logic             sys_clk,
    input  logic             dbg_rst,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic             step_req,
    input  logic [CNT_W-1:0] step_count,
    input  logic             bp_en,
    input  logic [CYC_W-1:0] bp_value,
    input  logic             clr_count,
    output logic             clk_en,
    output logic             halted,
    output logic             busy,
    output logic [1:0]       state,
    output logic [1:0]       halt_cause,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic [1:0] {
        S_RUN  = 2'b00,
        S_HALT = 2'b01,
        S_STEP = 2'b10,
        S_ILL  = 2'b11
    } state_e;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_HALT = 2'b01;
    localparam logic [1:0] C_STEP = 2'b10;
    localparam logic [1:0] C_BP   = 2'b11;

    state_e             state_q, state_d;
    logic               clk_en_q, clk_en_d;
    logic [1:0]         cause_q, cause_d;
    logic [CYC_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               bp_hit;

    // Compare uses the pre-increment count of a cycle that is actually enabled
    assign bp_hit = clk_en_q && bp_en && (cnt_q == bp_value);

    // Next-state: breakpoint beats halt beats resume beats step/completion
    always_comb begin
        state_d  = state_q;
        clk_en_d = clk_en_q;
        cause_d  = cause_q;
        rem_d    = rem_q;
        cnt_d    = clk_en_q ? cnt_q + CYC_W'(1) : cnt_q;

        case (state_q)
            S_RUN: begin
                if (bp_hit) begin
                    state_d  = S_HALT;
                    clk_en_d = 1'b0;
                    cause_d  = C_BP;
                end else if (halt_req) begin
                    state_d  = S_HALT;
                    clk_en_d = 1'b0;
                    cause_d  = C_HALT;
                end
            end
            S_HALT: begin
                clk_en_d = 1'b0;
                if (clr_count) cnt_d = '0;
                if (resume_req) begin
                    state_d  = S_RUN;
                    clk_en_d = 1'b1;
                    cause_d  = C_NONE;
                end else if (step_req) begin
                    state_d  = S_STEP;
                    clk_en_d = 1'b1;
                    cause_d  = C_NONE;
                    rem_d    = (step_count == '0) ? CNT_W'(1) : step_count;
                end
            end
            S_STEP: begin
                rem_d = rem_q - CNT_W'(1);
                if (bp_hit) begin
                    state_d  = S_HALT;
                    clk_en_d = 1'b0;
                    cause_d  = C_BP;
                    rem_d    = '0;
                end else if (halt_req) begin
                    state_d  = S_HALT;
                    clk_en_d = 1'b0;
                    cause_d  = C_HALT;
                    rem_d    = '0;
                end else if (resume_req) begin
                    state_d  = S_RUN;
                    clk_en_d = 1'b1;
                    cause_d  = C_NONE;
                    rem_d    = '0;
                end else if (rem_q <= CNT_W'(1)) begin
                    // last enabled cycle of the step is this edge
                    state_d  = S_HALT;
                    clk_en_d = 1'b0;
                    cause_d  = C_STEP;
                    rem_d    = '0;
                end
            end
            default: begin
                state_d  = S_RUN;
                clk_en_d = 1'b1;
                rem_d    = '0;
            end
        endcase
    end

    // State and counters; reset leaves the core running with the clock enabled
    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            state_q  <= S_RUN;
            clk_en_q <= 1'b1;
            cause_q  <= C_NONE;
            cnt_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= clk_en_d;
            cause_q  <= cause_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
        end
    end

    assign clk_en      = clk_en_q;
    assign halted      = (state_q == S_HALT);
    assign busy        = (state_q == S_STEP);
    assign state       = state_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cnt_q;
    assign remaining   = rem_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl: directed scenarios plus random strobes checked
// against a cycle-level behavioural model of the run-control rules.
module tb_dbg_run_ctrl;

    logic        sys_clk = 1'b0;
    logic        dbg_rst = 1'b0;
    logic        halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0;
    logic [7:0]  step_count = '0;
    logic        bp_en = 1'b0;
    logic [15:0] bp_value = '0;
    logic        clr_count = 1'b0;
    logic        clk_en, halted, busy;
    logic [1:0]  state, halt_cause;
    logic [15:0] cycle_count;
    logic [7:0]  remaining;

    logic        sm_rst = 1'b0;
    logic        sm_clk_en, sm_halted, sm_busy;
    logic [1:0]  sm_state, sm_cause;
    logic [3:0]  sm_count;
    logic [7:0]  sm_rem;

    int total = 0;
    int bad = 0;

    // model state: st 0=run 1=halt 2=step
    int          m_st;
    logic [1:0]  m_cause;
    logic [15:0] m_cnt;
    int          m_rem;

    always #5 sys_clk = ~sys_clk;

    dbg_run_ctrl #(.CNT_W(8), .CYC_W(16)) dut (
        .sys_clk(sys_clk), .dbg_rst(dbg_rst), .halt_req(halt_req),
        .resume_req(resume_req), .step_req(step_req), .step_count(step_count),
        .bp_en(bp_en), .bp_value(bp_value), .clr_count(clr_count),
        .clk_en(clk_en), .halted(halted), .busy(busy), .state(state),
        .halt_cause(halt_cause), .cycle_count(cycle_count), .remaining(remaining)
    );

    dbg_run_ctrl #(.CNT_W(8), .CYC_W(4)) dut_small (
        .sys_clk(sys_clk), .dbg_rst(sm_rst), .halt_req(1'b0),
        .resume_req(1'b0), .step_req(1'b0), .step_count(8'd0),
        .bp_en(1'b0), .bp_value(4'd0), .clr_count(1'b0),
        .clk_en(sm_clk_en), .halted(sm_halted), .busy(sm_busy), .state(sm_state),
        .halt_cause(sm_cause), .cycle_count(sm_count), .remaining(sm_rem)
    );

    function automatic logic [30:0] mexp();
        logic en;
        en = (m_st != 1);
        return {2'(m_st), en, m_cause, m_cnt, 8'(m_rem), m_st == 1, m_st == 2};
    endfunction

    function automatic logic [30:0] dvec();
        return {state, clk_en, halt_cause, cycle_count, remaining, halted, busy};
    endfunction

    task automatic mdl_reset();
        m_st = 0; m_cause = 2'b00; m_cnt = '0; m_rem = 0;
    endtask

    // One posedge of the rules: the clock is enabled exactly when not halted
    task automatic mdl_edge();
        bit en, bp;
        en = (m_st != 1);
        bp = en && bp_en && (m_cnt == bp_value);
        if (en) m_cnt = m_cnt + 16'd1;
        if (m_st == 0) begin
            if (bp)            begin m_st = 1; m_cause = 2'b11; end
            else if (halt_req) begin m_st = 1; m_cause = 2'b01; end
        end else if (m_st == 1) begin
            if (clr_count) m_cnt = '0;
            if (resume_req)    begin m_st = 0; m_cause = 2'b00; end
            else if (step_req) begin
                m_st = 2; m_cause = 2'b00;
                m_rem = (step_count == 0) ? 1 : int'(step_count);
            end
        end else begin
            if (bp)              begin m_st = 1; m_cause = 2'b11; m_rem = 0; end
            else if (halt_req)   begin m_st = 1; m_cause = 2'b01; m_rem = 0; end
            else if (resume_req) begin m_st = 0; m_cause = 2'b00; m_rem = 0; end
            else if (m_rem == 1) begin m_st = 1; m_cause = 2'b10; m_rem = 0; end
            else m_rem = m_rem - 1;
        end
    endtask

    // Advance one clock with the currently driven inputs, then drop strobes
    task automatic cyc();
        @(posedge sys_clk);
        mdl_edge();
        #1;
        halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0; clr_count = 1'b0;
    endtask

    task automatic test_reset();
        dbg_rst = 1'b0; sm_rst = 1'b0;
        mdl_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (dvec() !== {2'b00, 1'b1, 2'b00, 16'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset: got %h want %h", dvec(), {2'b00, 1'b1, 2'b00, 16'd0, 8'd0, 1'b0, 1'b0});
        end
        dbg_rst = 1'b1; sm_rst = 1'b1;
    endtask

    task automatic test_halt();
        repeat (10) cyc();
        total++;
        if (cycle_count !== 16'd10 || clk_en !== 1'b1 || state !== 2'b00) begin
            bad++; $display("FAIL run10: count=%0d en=%b st=%b want 10/1/00", cycle_count, clk_en, state);
        end
        halt_req = 1'b1;
        cyc();
        total++;
        if (clk_en !== 1'b0 || halted !== 1'b1 || halt_cause !== 2'b01 || cycle_count !== 16'd11) begin
            bad++; $display("FAIL halt: en=%b halted=%b cause=%b count=%0d want 0/1/01/11", clk_en, halted, halt_cause, cycle_count);
        end
        halt_req = 1'b1;
        repeat (3) cyc();
        total++;
        if (dvec() !== mexp() || cycle_count !== 16'd11 || halt_cause !== 2'b01) begin
            bad++; $display("FAIL halt_frozen: got %h want %h", dvec(), mexp());
        end
    endtask

    task automatic test_step();
        logic [15:0] c0;
        int n;
        for (int k = 0; k < 2; k++) begin
            c0 = cycle_count;
            n = 0;
            step_count = (k == 0) ? 8'd3 : 8'd0;
            step_req = 1'b1;
            cyc();
            for (int t = 0; t < 12; t++) begin
                if (clk_en === 1'b1) n++;
                cyc();
                if (halted === 1'b1) break;
            end
            total++;
            if (n != ((k == 0) ? 3 : 1) || cycle_count !== c0 + 16'((k == 0) ? 3 : 1)) begin
                bad++; $display("FAIL step%0d_len: en_cycles=%0d delta=%0d want %0d", k, n, cycle_count - c0, (k == 0) ? 3 : 1);
            end
            total++;
            if (state !== 2'b01 || halt_cause !== 2'b10 || remaining !== 8'd0 || dvec() !== mexp()) begin
                bad++; $display("FAIL step%0d_end: got %h want %h", k, dvec(), mexp());
            end
        end
    endtask

    task automatic test_breakpoint();
        clr_count = 1'b1;
        cyc();
        total++;
        if (cycle_count !== 16'd0) begin
            bad++; $display("FAIL clr_halt: count=%0d want 0", cycle_count);
        end
        bp_en = 1'b1; bp_value = 16'd20;
        resume_req = 1'b1;
        cyc();
        for (int t = 0; t < 40; t++) begin
            if (halted === 1'b1) break;
            cyc();
        end
        total++;
        if (cycle_count !== 16'd21 || halt_cause !== 2'b11 || clk_en !== 1'b0 || dvec() !== mexp()) begin
            bad++; $display("FAIL bp: count=%0d cause=%b en=%b want 21/11/0", cycle_count, halt_cause, clk_en);
        end
        bp_en = 1'b0;
    endtask

    task automatic test_step_abort();
        step_count = 8'd50; step_req = 1'b1;
        cyc();
        repeat (5) cyc();
        total++;
        if (remaining !== 8'd45 || busy !== 1'b1) begin
            bad++; $display("FAIL step50_mid: rem=%0d busy=%b want 45/1", remaining, busy);
        end
        halt_req = 1'b1;
        cyc();
        total++;
        if (state !== 2'b01 || halt_cause !== 2'b01 || remaining !== 8'd0 || clk_en !== 1'b0) begin
            bad++; $display("FAIL step_abort: st=%b cause=%b rem=%0d en=%b want 01/01/0/0", state, halt_cause, remaining, clk_en);
        end
        resume_req = 1'b1;
        cyc();
        repeat (2) cyc();
        halt_req = 1'b1; resume_req = 1'b1;
        cyc();
        total++;
        if (halted !== 1'b1 || halt_cause !== 2'b01 || dvec() !== mexp()) begin
            bad++; $display("FAIL halt_vs_resume: got %h want %h", dvec(), mexp());
        end
    endtask

    task automatic test_step_resume();
        int drops = 0;
        logic [15:0] c1;
        step_count = 8'd8; step_req = 1'b1;
        cyc();
        cyc();
        resume_req = 1'b1;
        cyc();
        for (int t = 0; t < 12; t++) begin
            if (clk_en !== 1'b1) drops++;
            cyc();
        end
        total++;
        if (state !== 2'b00 || drops != 0 || remaining !== 8'd0 || halt_cause !== 2'b00) begin
            bad++; $display("FAIL step_resume: st=%b drops=%0d rem=%0d cause=%b want 00/0/0/00", state, drops, remaining, halt_cause);
        end
        c1 = cycle_count;
        clr_count = 1'b1;
        cyc();
        total++;
        if (cycle_count !== c1 + 16'd1 || dvec() !== mexp()) begin
            bad++; $display("FAIL clr_in_run: count=%0d want %0d", cycle_count, c1 + 16'd1);
        end
    endtask

    task automatic test_async_reset();
        halt_req = 1'b1;
        cyc();
        step_count = 8'd50; step_req = 1'b1;
        cyc();
        repeat (3) cyc();
        #2 dbg_rst = 1'b0;
        #1;
        total++;
        if (dvec() !== {2'b00, 1'b1, 2'b00, 16'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL async_rst: got %h want %h", dvec(), {2'b00, 1'b1, 2'b00, 16'd0, 8'd0, 1'b0, 1'b0});
        end
        dbg_rst = 1'b1;
        mdl_reset();
        #1;
        total++;
        if (state !== 2'b00 || clk_en !== 1'b1 || cycle_count !== 16'd0) begin
            bad++; $display("FAIL after_rst: st=%b en=%b count=%0d want 00/1/0", state, clk_en, cycle_count);
        end
        cyc();
        total++;
        if (dvec() !== mexp()) begin
            bad++; $display("FAIL after_rst_run: got %h want %h", dvec(), mexp());
        end
    endtask

    task automatic test_wrap();
        #2 sm_rst = 1'b0;
        #1 sm_rst = 1'b1;
        repeat (17) cyc();
        total++;
        if (sm_count !== 4'd1 || sm_clk_en !== 1'b1) begin
            bad++; $display("FAIL wrap: count=%0d en=%b want 1/1", sm_count, sm_clk_en);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            halt_req   = ($urandom_range(0, 99) < 6);
            resume_req = ($urandom_range(0, 99) < 15);
            step_req   = ($urandom_range(0, 99) < 25);
            clr_count  = ($urandom_range(0, 99) < 10);
            step_count = 8'($urandom_range(0, 6));
            bp_en      = ($urandom_range(0, 99) < 30);
            bp_value   = m_cnt + 16'($urandom_range(0, 4));
            cyc();
            total++;
            if (dvec() !== mexp()) begin
                bad++; errs++;
                if (errs <= 5) $display("FAIL random[%0d]: got %h want %h", i, dvec(), mexp());
            end
        end
        bp_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_halt();
        test_step();
        test_breakpoint();
        test_step_abort();
        test_step_resume();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
